// File: rtl/permutation_arbiter.sv
// Round-robin sequencer sharing one permutation controller among NREQ clients; Moore outputs, 2-cycle req->start.
// Clients hold req until done; optional watchdog abort when PERM_ARB_TIMEOUT_EN is defined.
module permutation_arbiter #(
    parameter int NREQ = 4,
    parameter int IDXW = 2
`ifdef PERM_ARB_TIMEOUT_EN
    ,
    parameter int TO_CYC = 255
`endif
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    input  logic            permReady,
    output logic            permStart,
    output logic [NREQ-1:0] grant,
    output logic [IDXW-1:0] selIdx,
    output logic [NREQ-1:0] done,
    output logic            busy,
    output logic            err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_GRANT,
        S_START,
        S_WLOW,
        S_WHIGH,
        S_DONE,
        S_ABORT
    } state_t;

    state_t          state_q, state_d;
    logic [IDXW-1:0] rr_q, rr_d;
    logic [IDXW-1:0] owner_q, owner_d;

    logic [NREQ-1:0] req_rot;
    logic [IDXW-1:0] win_off;
    logic [IDXW:0]   win_sum;
    logic [IDXW-1:0] win;
    logic            win_vld;
    logic [IDXW-1:0] owner_nxt;
    logic [NREQ-1:0] owner_oh;
    logic            in_run;
    logic            timeout;

    // Rotate requests so bit 0 is the client at rrPtr, then take the lowest set bit.
    always_comb begin
        req_rot = NREQ'({req, req} >> rr_q);
        win_off = '0;
        win_vld = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (!win_vld && req_rot[i]) begin
                win_off = IDXW'(i);
                win_vld = 1'b1;
            end
        end
        win_sum = {1'b0, rr_q} + {1'b0, win_off};
        win     = (win_sum >= (IDXW+1)'(NREQ)) ? IDXW'(win_sum - (IDXW+1)'(NREQ))
                                               : win_sum[IDXW-1:0];
    end

    assign owner_nxt = (owner_q == IDXW'(NREQ - 1)) ? '0 : owner_q + 1'b1;
    assign owner_oh  = NREQ'(1) << owner_q;

`ifdef PERM_ARB_TIMEOUT_EN
    localparam int CW = ($clog2(TO_CYC + 1) > 8) ? $clog2(TO_CYC + 1) : 8;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (state_q == S_START) begin
            cnt_d = '0;
        end else if (state_q == S_WLOW || state_q == S_WHIGH) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    assign timeout = (cnt_q == CW'(TO_CYC - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        owner_d = owner_q;
        case (state_q)
            S_IDLE: begin
                if (win_vld && permReady) begin
                    owner_d = win;
                    state_d = S_GRANT;
                end
            end
            S_GRANT: state_d = S_START;
            S_START: state_d = S_WLOW;
            // A normal exit wins over a watchdog expiry landing on the same cycle.
            S_WLOW: begin
                if (!permReady) state_d = S_WHIGH;
                else if (timeout) state_d = S_ABORT;
            end
            S_WHIGH: begin
                if (permReady) state_d = S_DONE;
                else if (timeout) state_d = S_ABORT;
            end
            S_DONE, S_ABORT: begin
                rr_d    = owner_nxt;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            rr_q    <= '0;
            owner_q <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            owner_q <= owner_d;
        end
    end

    assign in_run    = (state_q == S_GRANT) || (state_q == S_START) || (state_q == S_WLOW) ||
                       (state_q == S_WHIGH) || (state_q == S_DONE);
    assign permStart = (state_q == S_START);
    assign grant     = in_run ? owner_oh : '0;
    assign selIdx    = in_run ? owner_q : '0;
    assign done      = (state_q == S_DONE) ? owner_oh : '0;
    assign busy      = (state_q != S_IDLE);
`ifdef PERM_ARB_TIMEOUT_EN
    assign err       = (state_q == S_ABORT);
`else
    assign err       = 1'b0;
`endif

endmodule

// File: tb/tb_permutation_arbiter.sv
// Bench for permutation_arbiter: directed scenarios plus random request patterns against a round-robin model.
module tb_permutation_arbiter;
    localparam int NREQ = 4;
    localparam int IDXW = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic [NREQ-1:0] req;
    logic            permReady;
    logic            permStart;
    logic [NREQ-1:0] grant;
    logic [IDXW-1:0] selIdx;
    logic [NREQ-1:0] done;
    logic            busy;
    logic            err;

    int total = 0;
    int bad   = 0;
    int rr_m  = 0;

    always #5 clk = ~clk;

    permutation_arbiter #(
        .NREQ(NREQ),
        .IDXW(IDXW)
`ifdef PERM_ARB_TIMEOUT_EN
        ,
        .TO_CYC(8)
`endif
    ) dut (
        .clk(clk),
        .rst(rst),
        .req(req),
        .permReady(permReady),
        .permStart(permStart),
        .grant(grant),
        .selIdx(selIdx),
        .done(done),
        .busy(busy),
        .err(err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Round-robin rule: first requesting client at or after the pointer, wrapping.
    function automatic int pick(input logic [NREQ-1:0] rq, input int rr);
        for (int k = 0; k < NREQ; k++) begin
            if (rq[(rr + k) % NREQ]) return (rr + k) % NREQ;
        end
        return -1;
    endfunction

    function automatic logic [NREQ-1:0] oh(input int i);
        logic [NREQ-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    task automatic check_all_zero(input string tag);
        chk({tag, "_grant"}, grant, 0);
        chk({tag, "_start"}, permStart, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_err"}, err, 0);
        chk({tag, "_sel"}, selIdx, 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        permReady = 1'b1;
        tick();
        tick();
        check_all_zero("reset");
        rst  = 1'b0;
        rr_m = 0;
    endtask

    // One complete run: controller stays busy for bz cycles after leaving idle.
    task automatic serve(input logic [NREQ-1:0] rq, input int bz, input bit drop);
        int w;
        w   = pick(rq, rr_m);
        req = rq;
        tick();
        chk("grant", grant, oh(w));
        chk("selIdx", selIdx, w);
        chk("start_early", permStart, 0);
        chk("busy", busy, 1);
        tick();
        chk("start", permStart, 1);
        chk("grant_start", grant, oh(w));
        permReady = 1'b0;
        tick();
        chk("start_once", permStart, 0);
        tick();
        for (int c = 0; c < bz; c++) begin
            if (drop) req = '0;
            chk("done_early", done, 0);
            chk("grant_run", grant, oh(w));
            tick();
        end
        permReady = 1'b1;
        tick();
        chk("done", done, oh(w));
        chk("grant_done", grant, oh(w));
        rr_m = (w + 1) % NREQ;
        tick();
        chk("done_clear", done, 0);
        chk("idle_grant", grant, 0);
        chk("idle_busy", busy, 0);
    endtask

    initial begin
        logic [NREQ-1:0] rq;
        int w;

        do_reset();

        // single requester, 4-cycle controller run
        serve(4'b0010, 4, 1'b0);

        // all requesting: rotation and wrap
        do_reset();
        for (int n = 0; n < 5; n++) serve(4'b1111, 2, 1'b0);

        // pointer at 1 with clients 0 and 2 pending
        do_reset();
        serve(4'b0001, 1, 1'b0);
        serve(4'b0101, 1, 1'b0);
        serve(4'b0101, 1, 1'b0);

        // req dropped mid-run still completes, then client 2 is ignored
        serve(4'b0100, 2, 1'b1);
        tick();
        chk("drop_idle_grant", grant, 0);
        chk("drop_idle_busy", busy, 0);
        serve(4'b0011, 1, 1'b0);

        // controller not ready in IDLE blocks arbitration
        permReady = 1'b0;
        req = 4'b0001;
        for (int c = 0; c < 10; c++) begin
            tick();
            chk("notready_grant", grant, 0);
            chk("notready_start", permStart, 0);
        end
        permReady = 1'b1;
        serve(4'b0001, 1, 1'b0);

        // reset while waiting for controller completion
        req = 4'b1000;
        tick();
        tick();
        permReady = 1'b0;
        tick();
        tick();
        chk("whigh_busy", busy, 1);
        rst = 1'b1;
        tick();
        check_all_zero("midrst");
        rst = 1'b0;
        req = '0;
        permReady = 1'b1;
        rr_m = 0;
        tick();

        // random request patterns and controller run lengths
        for (int n = 0; n < 24; n++) begin
            rq = NREQ'($urandom_range(1, (1 << NREQ) - 1));
            serve(rq, int'($urandom_range(0, 5)), 1'b0);
        end

`ifdef PERM_ARB_TIMEOUT_EN
        // controller never reports completion: watchdog aborts after 8 wait cycles
        w   = pick(4'b0010, rr_m);
        req = 4'b0010;
        tick();
        tick();
        chk("to_start", permStart, 1);
        permReady = 1'b0;
        for (int c = 0; c < 8; c++) begin
            tick();
            chk("to_err_early", err, 0);
            chk("to_busy", busy, 1);
        end
        tick();
        chk("to_err", err, 1);
        chk("to_no_done", done, 0);
        rr_m = (w + 1) % NREQ;
        req = '0;
        tick();
        chk("to_err_clear", err, 0);
        chk("to_idle", busy, 0);
        permReady = 1'b1;
        serve(4'b1111, 1, 1'b0);
`else
        w = 0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
